// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, state
// encodings, datapath mux codes and the packed control word.
package mips_pkg;

    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       ir_en;
        logic       mem_req;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode of the registered FSM state into the datapath control
// word; only FETCH looks at mem_ready, to qualify the PC/IR loads.
module mips_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.ir_en     = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            // Branch target is precomputed here so BRANCH can compare and load in one cycle.
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b0;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the multicycle MIPS datapath: state register, opcode
// latched in DECODE, next-state logic and reset gating of the write enables.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPW     = 6,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPW-1:0]     opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               ir_en,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl;
    logic           run;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE)
                op_q <= opcode;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // The live opcode may already have moved on; use the copy taken in DECODE.
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Reset suppresses every write-side strobe in the same cycle it is seen.
    assign run = ~reset;

    assign pc_en      = run & (ctrl.pc_write | (ctrl.branch & zero));
    assign ir_en      = run & ctrl.ir_en;
    assign mem_req    = run & ctrl.mem_req;
    assign mem_write  = run & ctrl.mem_write;
    assign reg_write  = run & ctrl.reg_write;
    assign iord       = ctrl.iord;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign illegal_op = run & (state_q == S_DECODE) & ~op_legal(opcode);
    assign state_dbg  = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multicycle MIPS controller: reset, LW walk, BEQ
// taken/not-taken, SW with memory stalls, illegal opcode, mid-LW reset, cycle counts.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] F   = 4'd0;
    localparam logic [3:0] D   = 4'd1;
    localparam logic [3:0] MA  = 4'd2;
    localparam logic [3:0] MR  = 4'd3;
    localparam logic [3:0] MWB = 4'd4;
    localparam logic [3:0] MW  = 4'd5;
    localparam logic [3:0] BR  = 4'd8;
    localparam logic [3:0] JP  = 4'd11;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_en, mem_req, mem_write, iord, reg_write, reg_dst, mem_to_reg;
    logic       alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_dbg;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.OPW(6), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .ir_en      (ir_en),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; zero = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            tests++;
            if (state_dbg !== F) begin
                fails++; $display("FAIL reset_state cyc%0d: got %0d want %0d", c, state_dbg, F);
            end
            tests++;
            if ({pc_en, ir_en, reg_write, mem_req, mem_write} !== 5'b0) begin
                fails++; $display("FAIL reset_enables cyc%0d: got %b want 00000", c,
                                  {pc_en, ir_en, reg_write, mem_req, mem_write});
            end
        end
        reset = 1'b0;
        #1;
        tests++;
        if ({pc_en, ir_en, mem_req, iord, alu_src_b} !== 6'b111001) begin
            fails++; $display("FAIL fetch_outputs: got %b want 111001",
                              {pc_en, ir_en, mem_req, iord, alu_src_b});
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{F, D, MA, MR, MWB, F};
        logic       exp_wb [6] = '{0, 0, 0, 0, 1, 0};
        mem_ready = 1'b1; opcode = 6'b100011;
        #1;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (state_dbg !== exp_st[i]) begin
                fails++; $display("FAIL lw_state step%0d: got %0d want %0d", i, state_dbg, exp_st[i]);
            end
            tests++;
            if ({reg_write, mem_to_reg} !== {exp_wb[i], exp_wb[i]}) begin
                fails++; $display("FAIL lw_wb step%0d: got %b want %b", i,
                                  {reg_write, mem_to_reg}, {exp_wb[i], exp_wb[i]});
            end
            if (i == 3) begin
                tests++;
                if ({mem_req, iord} !== 2'b11) begin
                    fails++; $display("FAIL lw_memrd_req: got %b want 11", {mem_req, iord});
                end
            end
            if (i < 5) tick();
        end
    endtask

    task automatic test_beq(input logic z);
        logic [3:0] exp_st [4] = '{F, D, BR, F};
        mem_ready = 1'b1; opcode = 6'b000100; zero = z;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (state_dbg !== exp_st[i]) begin
                fails++; $display("FAIL beq_state z%0b step%0d: got %0d want %0d", z, i, state_dbg, exp_st[i]);
            end
            if (i == 2) begin
                tests++;
                if ({pc_en, pc_src, alu_op} !== {z, 2'b01, 2'b01}) begin
                    fails++; $display("FAIL beq_branch z%0b: got %b want %b", z,
                                      {pc_en, pc_src, alu_op}, {z, 2'b01, 2'b01});
                end
            end
            if (i < 3) tick();
        end
    endtask

    task automatic test_sw_stall();
        mem_ready = 1'b1; opcode = 6'b101011; zero = 1'b0;
        #1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                mem_ready = 1'b1;
                #1;
            end
            tests++;
            if ({state_dbg, mem_req, mem_write, iord} !== {MW, 3'b111}) begin
                fails++; $display("FAIL sw_hold cyc%0d: got st=%0d req/wr/iord=%b want st=%0d 111", c,
                                  state_dbg, {mem_req, mem_write, iord}, MW);
            end
            tick();
        end
        tests++;
        if ({state_dbg, mem_write} !== {F, 1'b0}) begin
            fails++; $display("FAIL sw_done: got st=%0d wr=%b want st=0 wr=0", state_dbg, mem_write);
        end
    endtask

    task automatic test_illegal();
        mem_ready = 1'b1; opcode = 6'b111111;
        #1;
        tests++;
        if (illegal_op !== 1'b0) begin
            fails++; $display("FAIL illegal_fetch: got %b want 0", illegal_op);
        end
        tick();
        tests++;
        if ({state_dbg, illegal_op, reg_write} !== {D, 2'b10}) begin
            fails++; $display("FAIL illegal_decode: got st=%0d ill=%b rw=%b want st=1 ill=1 rw=0",
                              state_dbg, illegal_op, reg_write);
        end
        tick();
        tests++;
        if ({state_dbg, illegal_op, reg_write} !== {F, 2'b00}) begin
            fails++; $display("FAIL illegal_after: got st=%0d ill=%b rw=%b want st=0 ill=0 rw=0",
                              state_dbg, illegal_op, reg_write);
        end
    endtask

    task automatic test_reset_mid_lw();
        mem_ready = 1'b1; opcode = 6'b100011;
        #1;
        tick(); tick();
        mem_ready = 1'b0;
        tick();
        tests++;
        if (state_dbg !== MR) begin
            fails++; $display("FAIL midrst_in_memrd: got %0d want %0d", state_dbg, MR);
        end
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        tests++;
        if ({mem_req, reg_write, pc_en} !== 3'b000) begin
            fails++; $display("FAIL midrst_gated: got %b want 000", {mem_req, reg_write, pc_en});
        end
        tick();
        tests++;
        if ({state_dbg, reg_write} !== {F, 1'b0}) begin
            fails++; $display("FAIL midrst_fetch: got st=%0d rw=%b want st=0 rw=0", state_dbg, reg_write);
        end
        reset = 1'b0; mem_ready = 1'b0;
        #1;
        tick();
        tests++;
        if ({state_dbg, reg_write} !== {F, 1'b0}) begin
            fails++; $display("FAIL midrst_no_wb: got st=%0d rw=%b want st=0 rw=0", state_dbg, reg_write);
        end
    endtask

    task automatic test_cycle_counts();
        logic [5:0] ops  [6] = '{6'b000000, 6'b001000, 6'b000010, 6'b101011, 6'b100011, 6'b000100};
        int         cyc  [6] = '{4, 4, 3, 4, 5, 3};
        int         n;
        mem_ready = 1'b1; zero = 1'b0;
        for (int k = 0; k < 6; k++) begin
            opcode = ops[k];
            #1;
            n = 1;
            tick();
            while (state_dbg !== F && n < 20) begin
                if (state_dbg === JP) begin
                    tests++;
                    if ({pc_en, pc_src} !== 3'b110) begin
                        fails++; $display("FAIL jump_pc: got %b want 110", {pc_en, pc_src});
                    end
                end
                n++;
                tick();
            end
            tests++;
            if (n != cyc[k]) begin
                fails++; $display("FAIL cycles op=%b: got %0d want %0d", ops[k], n, cyc[k]);
            end
        end
    endtask

    initial begin
        reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_sw_stall();
        test_illegal();
        test_reset_mid_lw();
        test_cycle_counts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
